aliens_vram_arbiter: RTL and testbench
======================================

// Module: aliens_vram_arbiter
// PURPOSE
//  Serialises CPU and video-scanner accesses to the shared video RAM bank (VRAM/CRAM/OBJ RAM).
//  Sits downstream of the address-decode PAL: it takes the CPU's decoded region and drives the
//  registered active-low chip selects, write strobe and RAM address mux.
//  Inserts CPU wait states while the video fetch owns the bus, and bounds CPU starvation.
// PARAMETERS
//  ACCESS_CYC  2   cycles chip select is held per access (>=2; cycle 1 is address setup)
//  STARVE_MAX  3   consecutive CPU losses to video before CPU is forced to win (1..15)
//  RAM_AW      13  RAM address width
// PORTS
//  clk         in   1       system clock, all logic rising-edge
//  rst_n       in   1       synchronous active-low reset
//  cpu_req     in   1       CPU access request, held with addr/data until cpu_ack
//  cpu_region  in   2       00 none, 01 VRAM, 10 CRAM, 11 OBJ (from decoder)
//  cpu_rnw     in   1       1 read, 0 write
//  cpu_addr    in   RAM_AW  CPU word address within region
//  cpu_wdata   in   8       CPU write data
//  cpu_rdata   out  8       CPU read data, valid while cpu_ack=1
//  cpu_ack     out  1       one-cycle completion pulse
//  cpu_wait    out  1       cpu_req & ~cpu_ack (combinational; drives CPU wait pin)
//  vid_req     in   1       scanner VRAM read request, held until vid_ack
//  vid_addr    in   RAM_AW  scanner VRAM address
//  vid_rdata   out  8       scanner read data, valid while vid_ack=1
//  vid_ack     out  1       one-cycle completion pulse
//  ram_addr    out  RAM_AW  muxed RAM address
//  ram_wdata   out  8       RAM write data (= cpu_wdata latched at grant)
//  ram_rdata   in   8       RAM read data
//  ram_we_n    out  1       active-low write strobe
//  vramcs_n, cramcs_n, objcs_n  out 1 each  active-low chip selects
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE; all *cs_n, ram_we_n =1; acks 0; rdata 0; ram_addr 0;
//    starve counter 0. Applies mid-access: selects/strobe released at that same edge, no ack.
//  - FSM IDLE -> ACC (ACCESS_CYC cycles) -> DONE -> IDLE. Requests sampled only in IDLE.
//  - IDLE arbitration: vid_req only -> video; cpu_req (region!=00) only -> CPU; both -> video
//    unless starve==STARVE_MAX, then CPU. Video win with CPU pending: starve++ (saturating).
//    Any CPU grant clears starve. cpu_req with region 00: go straight to DONE, ack, no CS.
//  - ACC: grant owner's address, region and rnw latched at grant; matching cs_n=0 all ACC
//    cycles (video always VRAM). CPU write: ram_we_n=0 in ACC cycles 2..ACCESS_CYC only.
//  - Last ACC cycle: ram_rdata captured into owner's rdata register.
//  - DONE: owner's ack=1 for exactly one cycle, all cs_n=1, rdata held until next capture.
//  - Latency (ACCESS_CYC=2): request seen in IDLE cycle 0 -> CS cycles 1-2 -> ack cycle 3 ->
//    IDLE cycle 4. Back-to-back throughput one access per ACCESS_CYC+2 cycles.
//  - Abort: owner's req dropped during ACC -> access runs to completion, ack suppressed.
//  - Request held through DONE is not re-granted; requester must drop on seeing ack.
//  - At most one cs_n low at any time; ram_we_n never low while all cs_n high.
// STRUCTURE
//  - Shared package: region codes (REG_NONE/VRAM/CRAM/OBJ), FSM state enum, owner enum.
//  - Single module; access-cycle counter ($clog2(ACCESS_CYC+1) bits) and starve counter
//    (4 bits) inline. No sub-module.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with both reqs high -> all cs_n/we_n=1, acks 0 throughout.
//  2 CPU VRAM read alone, ram_rdata=8'hA5: vramcs_n=0 cycles 1-2, cpu_ack+rdata=A5 in
//    cycle 3, cpu_wait high cycles 0-2.
//  3 Simultaneous CPU CRAM write addr 0x012/data 0x3C and video read: video CS cycles 1-2,
//    vid_ack 3; cramcs_n=0 cycles 5-6, ram_we_n=0 cycle 6 only, cpu_ack 7.
//  4 Starvation: vid_req continuously re-asserted, CPU pending -> video wins 3 times, 4th
//    arbitration goes to CPU, starve returns to 0.
//  5 cpu_req region 00 -> cpu_ack cycle 1, no cs_n asserted.
//  6 Abort/reset: drop cpu_req in ACC cycle 1 -> CS still 2 cycles, no ack; rst_n=0 in ACC
//    cycle 1 -> all cs_n=1 next cycle, FSM IDLE.

Source files
------------

// File: rtl/aliens_vram_arbiter_pkg.sv
// Shared types for the video RAM arbiter: decoder region codes, FSM states and bus owner.
package aliens_vram_arbiter_pkg;

   typedef enum logic [1:0] {
      REG_NONE = 2'b00,
      REG_VRAM = 2'b01,
      REG_CRAM = 2'b10,
      REG_OBJ  = 2'b11
   } region_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_VID = 1'b1
   } owner_t;

   // Active-low select vector ordered {objcs_n, cramcs_n, vramcs_n}.
   function automatic logic [2:0] region_cs_n(input logic [1:0] region);
      logic [2:0] cs_n;
      cs_n = 3'b111;
      case (region)
         REG_VRAM: cs_n = 3'b110;
         REG_CRAM: cs_n = 3'b101;
         REG_OBJ:  cs_n = 3'b011;
         default:  cs_n = 3'b111;
      endcase
      return cs_n;
   endfunction

endpackage

// File: rtl/aliens_vram_arbiter.sv
// Serialises CPU and video-scanner accesses onto the shared video RAM bank with registered
// active-low selects, CPU wait-state generation and a bound on CPU starvation.
module aliens_vram_arbiter
   import aliens_vram_arbiter_pkg::*;
#(
   parameter int ACCESS_CYC = 2,
   parameter int STARVE_MAX = 3,
   parameter int RAM_AW     = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [1:0]        cpu_region,
   input  logic              cpu_rnw,
   input  logic [RAM_AW-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_wait,
   input  logic              vid_req,
   input  logic [RAM_AW-1:0] vid_addr,
   output logic [7:0]        vid_rdata,
   output logic              vid_ack,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic              ram_we_n,
   output logic              vramcs_n,
   output logic              cramcs_n,
   output logic              objcs_n,
   output logic [1:0]        state_dbg
);

   localparam int CW = $clog2(ACCESS_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(ACCESS_CYC);
   localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

   // Handshake: a requester raises req with its address/data held stable and keeps it up
   // until the one-cycle ack; it must drop req in the ack cycle, since a request still high
   // back in IDLE is treated as a new access. Dropping req early aborts the ack only.

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [3:0]          starve_q, starve_d;
   logic                rnw_q, rnw_d;
   logic                abort_q, abort_d;
   logic [2:0]          cs_n_q, cs_n_d;
   logic                we_n_q, we_n_d;
   logic [RAM_AW-1:0]   addr_q, addr_d;
   logic [7:0]          wdata_q, wdata_d;
   logic                cpu_ack_q, cpu_ack_d;
   logic                vid_ack_q, vid_ack_d;
   logic [7:0]          cpu_rdata_q, cpu_rdata_d;
   logic [7:0]          vid_rdata_q, vid_rdata_d;

   logic cpu_valid;
   logic owner_req;

   assign cpu_valid = cpu_req && (cpu_region != REG_NONE);
   assign owner_req = (owner_q == OWN_CPU) ? cpu_req : vid_req;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_CPU;
         cnt_q       <= '0;
         starve_q    <= 4'd0;
         rnw_q       <= 1'b1;
         abort_q     <= 1'b0;
         cs_n_q      <= 3'b111;
         we_n_q      <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= 8'h00;
         cpu_ack_q   <= 1'b0;
         vid_ack_q   <= 1'b0;
         cpu_rdata_q <= 8'h00;
         vid_rdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         starve_q    <= starve_d;
         rnw_q       <= rnw_d;
         abort_q     <= abort_d;
         cs_n_q      <= cs_n_d;
         we_n_q      <= we_n_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         vid_ack_q   <= vid_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         vid_rdata_q <= vid_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      starve_d    = starve_q;
      rnw_d       = rnw_q;
      abort_d     = abort_q;
      cs_n_d      = 3'b111;
      we_n_d      = 1'b1;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_ack_d   = 1'b0;
      vid_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      vid_rdata_d = vid_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (vid_req && !(cpu_valid && starve_q == STARVE_LIM)) begin
               owner_d = OWN_VID;
               rnw_d   = 1'b1;
               addr_d  = vid_addr;
               cs_n_d  = region_cs_n(REG_VRAM);
               cnt_d   = CW'(1);
               abort_d = 1'b0;
               state_d = ST_ACC;
               if (cpu_valid && starve_q != 4'hF)
                  starve_d = starve_q + 4'd1;
            end else if (cpu_valid) begin
               owner_d  = OWN_CPU;
               rnw_d    = cpu_rnw;
               addr_d   = cpu_addr;
               wdata_d  = cpu_wdata;
               cs_n_d   = region_cs_n(cpu_region);
               cnt_d    = CW'(1);
               abort_d  = 1'b0;
               starve_d = 4'd0;
               state_d  = ST_ACC;
            end else if (cpu_req) begin
               // Unmapped region: complete immediately without touching the RAM.
               owner_d   = OWN_CPU;
               cpu_ack_d = 1'b1;
               state_d   = ST_DONE;
            end
         end

         ST_ACC: begin
            if (!owner_req)
               abort_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               if (owner_q == OWN_CPU) begin
                  cpu_rdata_d = ram_rdata;
                  cpu_ack_d   = owner_req && !abort_q;
               end else begin
                  vid_rdata_d = ram_rdata;
                  vid_ack_d   = owner_req && !abort_q;
               end
            end else begin
               cnt_d  = cnt_q + 1'b1;
               cs_n_d = cs_n_q;
               // Cycle 1 is address setup; the strobe covers the remaining cycles.
               we_n_d = !((owner_q == OWN_CPU) && !rnw_q);
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_wait  = cpu_req & ~cpu_ack_q;
   assign vid_rdata = vid_rdata_q;
   assign vid_ack   = vid_ack_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign ram_we_n  = we_n_q;
   assign vramcs_n  = cs_n_q[0];
   assign cramcs_n  = cs_n_q[1];
   assign objcs_n   = cs_n_q[2];
   assign state_dbg = state_q;

endmodule

// File: tb/tb_aliens_vram_arbiter.sv
// Directed bench for aliens_vram_arbiter: expected RAM bursts and acks are queued at issue
// time and a negedge monitor pops and compares them as the DUT produces them.
module tb_aliens_vram_arbiter;
   import aliens_vram_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req;
   logic [1:0]  cpu_region;
   logic        cpu_rnw;
   logic [12:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        cpu_wait;
   logic        vid_req;
   logic [12:0] vid_addr;
   logic [7:0]  vid_rdata;
   logic        vid_ack;
   logic [12:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        ram_we_n;
   logic        vramcs_n;
   logic        cramcs_n;
   logic        objcs_n;
   logic [1:0]  state_dbg;

   aliens_vram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_region(cpu_region), .cpu_rnw(cpu_rnw),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .ram_we_n(ram_we_n), .vramcs_n(vramcs_n), .cramcs_n(cramcs_n), .objcs_n(objcs_n),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   typedef struct {
      logic [2:0]  cs_n;
      logic [12:0] addr;
      logic [7:0]  wdata;
      int          start;
      int          len;
      int          we_cnt;
      int          we_first;
   } bus_t;

   typedef struct {
      logic       is_cpu;
      int         at;
      logic       chk_data;
      logic [7:0] data;
   } ack_t;

   bus_t bus_q[$];
   ack_t exp_q[$];

   int errors = 0;
   int checks = 0;
   int n_acks = 0;
   int n_bursts = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_bus(input logic [2:0] cs_n, input logic [12:0] addr, input logic [7:0] wdata,
                          input int start, input int len, input int we_cnt, input int we_first);
      bus_t b;
      b.cs_n = cs_n; b.addr = addr; b.wdata = wdata; b.start = start;
      b.len = len; b.we_cnt = we_cnt; b.we_first = we_first;
      bus_q.push_back(b);
   endtask

   task automatic exp_ack(input logic is_cpu, input int at, input logic chk_data, input logic [7:0] data);
      ack_t a;
      a.is_cpu = is_cpu; a.at = at; a.chk_data = chk_data; a.data = data;
      exp_q.push_back(a);
   endtask

   // ---------------- monitor ----------------
   logic        in_burst = 1'b0;
   bus_t        cur;

   always @(negedge clk) begin
      logic [2:0] cs_low;
      bus_t       eb;
      ack_t       ea;
      cs_low = ~{objcs_n, cramcs_n, vramcs_n};

      chk("one_cs_max", {31'd0, ($countones(cs_low) > 1)}, 32'd0);
      chk("we_without_cs", {31'd0, (!ram_we_n && cs_low == 3'b000)}, 32'd0);
      chk("cpu_wait", {31'd0, cpu_wait}, {31'd0, cpu_req & ~cpu_ack});

      if (cs_low != 3'b000) begin
         if (!in_burst) begin
            in_burst     = 1'b1;
            cur.cs_n     = {objcs_n, cramcs_n, vramcs_n};
            cur.addr     = ram_addr;
            cur.wdata    = 8'h00;
            cur.start    = cyc;
            cur.len      = 0;
            cur.we_cnt   = 0;
            cur.we_first = -1;
         end
         cur.len++;
         if (!ram_we_n) begin
            if (cur.we_cnt == 0) cur.we_first = cyc;
            cur.we_cnt++;
            cur.wdata = ram_wdata;
         end
      end else if (in_burst) begin
         in_burst = 1'b0;
         n_bursts++;
         if (bus_q.size() == 0) begin
            chk("unexpected_burst_start", cur.start, 32'hFFFF_FFFF);
         end else begin
            eb = bus_q.pop_front();
            chk("burst_cs_n", {29'd0, cur.cs_n}, {29'd0, eb.cs_n});
            chk("burst_addr", {19'd0, cur.addr}, {19'd0, eb.addr});
            chk("burst_start", cur.start, eb.start);
            chk("burst_len", cur.len, eb.len);
            chk("burst_we_cnt", cur.we_cnt, eb.we_cnt);
            if (eb.we_cnt > 0) begin
               chk("burst_we_first", cur.we_first, eb.we_first);
               chk("burst_wdata", {24'd0, cur.wdata}, {24'd0, eb.wdata});
            end
         end
      end

      if (cpu_ack || vid_ack) begin
         n_acks++;
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", {30'd0, cpu_ack, vid_ack}, 32'd0);
         end else begin
            ea = exp_q.pop_front();
            chk("ack_src", {30'd0, cpu_ack, vid_ack}, ea.is_cpu ? 32'd2 : 32'd1);
            chk("ack_cycle", cyc, ea.at);
            if (ea.chk_data)
               chk("ack_rdata", {24'd0, (cpu_ack ? cpu_rdata : vid_rdata)}, {24'd0, ea.data});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_test(output int t0);
      @(posedge clk);
      #1;
      t0 = cyc;
   endtask

   task automatic cpu_access(input logic [1:0] region, input logic rnw,
                             input logic [12:0] addr, input logic [7:0] wdata);
      logic got;
      got        = 1'b0;
      cpu_region = region;
      cpu_rnw    = rnw;
      cpu_addr   = addr;
      cpu_wdata  = wdata;
      cpu_req    = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (cpu_ack) begin
            got = 1'b1;
            break;
         end
      end
      cpu_req    = 1'b0;
      cpu_region = 2'b00;
      if (!got) chk("cpu_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic vid_stream(input logic [12:0] base, input int n);
      logic got;
      for (int k = 0; k < n; k++) begin
         got      = 1'b0;
         vid_addr = base + 13'(k);
         vid_req  = 1'b1;
         for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (vid_ack) begin
               got = 1'b1;
               break;
            end
         end
         vid_req = 1'b0;
         if (!got) chk("vid_ack_timeout", 32'd0, 32'd1);
         if (k < n - 1) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic settle_and_drain(input int n);
      repeat (n) @(posedge clk);
      #1;
      chk("bus_q_drained", bus_q.size(), 32'd0);
      chk("exp_q_drained", exp_q.size(), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0;
      int acks_before;
      int bursts_before;

      rst_n      = 1'b0;
      cpu_req    = 1'b1;
      cpu_region = REG_VRAM;
      cpu_rnw    = 1'b1;
      cpu_addr   = 13'h0000;
      cpu_wdata  = 8'h00;
      vid_req    = 1'b1;
      vid_addr   = 13'h0000;
      ram_rdata  = 8'h00;

      // Reset held with both requests high.
      repeat (3) begin
         @(negedge clk);
         chk("rst_cs_n", {29'd0, objcs_n, cramcs_n, vramcs_n}, 32'd7);
         chk("rst_we_n", {31'd0, ram_we_n}, 32'd1);
         chk("rst_acks", {30'd0, cpu_ack, vid_ack}, 32'd0);
         chk("rst_rdata", {16'd0, cpu_rdata, vid_rdata}, 32'd0);
         chk("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      end
      cpu_req = 1'b0;
      vid_req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // CPU VRAM read alone.
      ram_rdata = 8'hA5;
      start_test(t0);
      exp_bus(3'b110, 13'h0ABC, 8'h00, t0 + 1, 2, 0, -1);
      exp_ack(1'b1, t0 + 3, 1'b1, 8'hA5);
      fork
         cpu_access(REG_VRAM, 1'b1, 13'h0ABC, 8'h00);
         begin
            @(negedge clk); chk("wait_c0", {31'd0, cpu_wait}, 32'd1);
            @(negedge clk); chk("wait_c1", {31'd0, cpu_wait}, 32'd1);
            @(negedge clk); chk("wait_c2", {31'd0, cpu_wait}, 32'd1);
            @(negedge clk); chk("wait_c3", {31'd0, cpu_wait}, 32'd0);
         end
      join
      settle_and_drain(3);

      // Simultaneous CPU CRAM write and video read: video first.
      ram_rdata = 8'h5A;
      start_test(t0);
      exp_bus(3'b110, 13'h1F00, 8'h00, t0 + 1, 2, 0, -1);
      exp_ack(1'b0, t0 + 3, 1'b1, 8'h5A);
      exp_bus(3'b101, 13'h0012, 8'h3C, t0 + 5, 2, 1, t0 + 6);
      exp_ack(1'b1, t0 + 7, 1'b0, 8'h00);
      fork
         cpu_access(REG_CRAM, 1'b0, 13'h0012, 8'h3C);
         vid_stream(13'h1F00, 1);
      join
      settle_and_drain(3);

      // Starvation bound: three video wins, then the CPU, then video again.
      ram_rdata = 8'h77;
      start_test(t0);
      exp_bus(3'b110, 13'h0100, 8'h00, t0 + 1, 2, 0, -1);
      exp_ack(1'b0, t0 + 3, 1'b1, 8'h77);
      exp_bus(3'b110, 13'h0101, 8'h00, t0 + 5, 2, 0, -1);
      exp_ack(1'b0, t0 + 7, 1'b1, 8'h77);
      exp_bus(3'b110, 13'h0102, 8'h00, t0 + 9, 2, 0, -1);
      exp_ack(1'b0, t0 + 11, 1'b1, 8'h77);
      exp_bus(3'b101, 13'h0345, 8'h00, t0 + 13, 2, 0, -1);
      exp_ack(1'b1, t0 + 15, 1'b1, 8'h77);
      exp_bus(3'b110, 13'h0103, 8'h00, t0 + 17, 2, 0, -1);
      exp_ack(1'b0, t0 + 19, 1'b1, 8'h77);
      fork
         cpu_access(REG_CRAM, 1'b1, 13'h0345, 8'h00);
         vid_stream(13'h0100, 4);
      join
      settle_and_drain(3);

      // Starve count cleared: next contention goes to video again.
      ram_rdata = 8'h11;
      start_test(t0);
      exp_bus(3'b110, 13'h0200, 8'h00, t0 + 1, 2, 0, -1);
      exp_ack(1'b0, t0 + 3, 1'b1, 8'h11);
      exp_bus(3'b110, 13'h0002, 8'h00, t0 + 5, 2, 0, -1);
      exp_ack(1'b1, t0 + 7, 1'b1, 8'h11);
      fork
         cpu_access(REG_VRAM, 1'b1, 13'h0002, 8'h00);
         vid_stream(13'h0200, 1);
      join
      settle_and_drain(3);

      // Unmapped region: immediate ack, no chip select.
      bursts_before = n_bursts;
      start_test(t0);
      exp_ack(1'b1, t0 + 1, 1'b0, 8'h00);
      cpu_access(REG_NONE, 1'b1, 13'h0005, 8'h00);
      settle_and_drain(4);
      chk("none_no_burst", n_bursts - bursts_before, 32'd0);

      // Abort: CPU drops req in ACC cycle 1; access completes, no ack.
      ram_rdata = 8'h99;
      acks_before = n_acks;
      start_test(t0);
      exp_bus(3'b011, 13'h0777, 8'h00, t0 + 1, 2, 0, -1);
      cpu_region = REG_OBJ;
      cpu_rnw    = 1'b1;
      cpu_addr   = 13'h0777;
      cpu_req    = 1'b1;
      @(posedge clk);
      #1;
      cpu_req    = 1'b0;
      cpu_region = REG_NONE;
      settle_and_drain(6);
      chk("abort_no_ack", n_acks - acks_before, 32'd0);

      // Reset in ACC cycle 1 of a CPU VRAM write.
      acks_before = n_acks;
      start_test(t0);
      exp_bus(3'b110, 13'h0040, 8'h00, t0 + 1, 1, 0, -1);
      cpu_region = REG_VRAM;
      cpu_rnw    = 1'b0;
      cpu_addr   = 13'h0040;
      cpu_wdata  = 8'hEE;
      cpu_req    = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_cs_active", {31'd0, vramcs_n}, 32'd0);
      rst_n      = 1'b0;
      cpu_req    = 1'b0;
      cpu_region = REG_NONE;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid_rst_cs_n", {29'd0, objcs_n, cramcs_n, vramcs_n}, 32'd7);
      chk("mid_rst_we_n", {31'd0, ram_we_n}, 32'd1);
      chk("mid_rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      settle_and_drain(6);
      chk("mid_rst_no_ack", n_acks - acks_before, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation reached time %0t without finishing", $time);
      $fatal(1);
   end

endmodule
